fp_sqrt_sched: RTL and testbench
================================

# fp_sqrt_sched

Round-robin scheduler that shares one `fp_sqrt_wrapper` instance among `NREQ` requesters in the shared APU. It registers the winning operand into the unit and tracks each in-flight operation's requester ID in a latency-matched shift register. Each result is routed back to its originator through a registered result port. Per-requester outstanding counters bound in-flight work. A sticky error flag reports any mismatch between the expected and actual unit valid.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..16).
- `SQRT_LAT`, 2: unit latency in cycles. Must equal the unit's `C_SQRT_PIPE_REGS`.
- `MAX_OUTST`, 2: maximum in-flight operations per requester (1..7).

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: one clock; reset is synchronous and active-low.
- `req_i` in NREQ: per-requester request.
- `gnt_o` out NREQ: one-hot grant. Combinational from `req_i`, pointer and counters.
- `opa_i` in NREQ×FP_WIDTH: operands.
- `tag_i` in NREQ×WAPUTAG: requester tags.
- `rnd_i` in NREQ×NDSFLAGS_SQRT: rounding modes.
- `rvalid_o` out NREQ: one-hot result-valid pulse.
- `res_o` out FP_WIDTH: shared result bus.
- `tag_o` out WAPUTAG: tag of the delivered result.
- `status_o` out NUSFLAGS_SQRT: status of the delivered result.
- `unit_en_o` out 1: drives the unit's `En_i`.
- `unit_opa_o` out FP_WIDTH: drives the unit's `OpA_i`.
- `unit_tag_o` out WAPUTAG: drives the unit's `Tag_i`.
- `unit_rnd_o` out NDSFLAGS_SQRT: drives the unit's `Rnd_i`.
- `unit_valid_i` in 1: from the unit's `Valid_o`.
- `unit_res_i` in FP_WIDTH: from the unit's `Res_o`.
- `unit_tag_i` in WAPUTAG: from the unit's `Tag_o`.
- `unit_status_i` in NUSFLAGS_SQRT: from the unit's `Status_o`.
- `busy_o` out 1: any operation in flight or a result pending delivery.
- `err_o` out 1: sticky valid-mismatch error.

## Operation
Arbitration:
- Eligible set: requesters with `req_i[i]=1` and `outst[i] < MAX_OUTST`.
- Winner: the first eligible index scanning from `rr_ptr` upward, modulo NREQ. At most one grant per cycle.
- A transfer happens when `req_i[i] & gnt_o[i]`.
- On transfer, `rr_ptr` becomes the winner index + 1, modulo NREQ. With no transfer, `rr_ptr` holds.

Issue register:
- On transfer, `unit_en_o`, `unit_opa_o`, `unit_tag_o` and `unit_rnd_o` load the winner's values.
- With no transfer, `unit_en_o=0` and `unit_opa_o`, `unit_tag_o` and `unit_rnd_o` are forced to 0.

ID pipeline:
- Depth SQRT_LAT + 1, aligned so that stage SQRT_LAT coincides with `unit_valid_i`.
- Each stage holds a valid bit and a `$clog2(NREQ)` ID.
- Stage 0 loads alongside the issue register.

Result register:
- When the ID pipe's last-stage valid and `unit_valid_i` are both 1, register `unit_res_i`, `unit_tag_i` and `unit_status_i`.
- In the same case, `rvalid_o` becomes one-hot at the pipeline ID for exactly one cycle.
- Otherwise `rvalid_o=0` and the data outputs hold.

Outstanding counters (`outst[i]`, 3 bits):
- Increment on transfer from requester i.
- Decrement on `rvalid_o[i]`.
- Both in the same cycle: unchanged.
- Cannot exceed MAX_OUTST or drop below 0 by construction.

Other outputs:
- Error: when the last-stage valid differs from `unit_valid_i`, set `err_o`; it clears only on reset. A mismatched result is dropped, with no `rvalid_o` and no counter decrement.
- `busy_o`: OR of all ID-pipe valids, the issue `unit_en_o` and any nonzero `outst`.

## Timing
Latency:
- Transfer in cycle t.
- `unit_en_o=1` in cycle t+1.
- `unit_valid_i` in cycle t+1+SQRT_LAT.
- `rvalid_o` in cycle t+2+SQRT_LAT. Total is SQRT_LAT+2 cycles; with default parameters, a transfer at cycle 0 yields `rvalid_o` at cycle 4.

Throughput and ordering:
- Throughput is one issue per cycle.
- Results return in issue order.

Reset (`rst_ni=0` at a clock edge):
- Cleared: `rr_ptr`, all counters, the ID pipe, the issue register, the result register, `rvalid_o`, `err_o` and `busy_o`.
- `gnt_o` is 0 while `rst_ni=0`.
- Reset mid-operation discards in-flight work. Results emerging after reset with an empty ID pipe raise `err_o`; the integrator resets the unit together with the scheduler.

Grant while full:
- A requester at MAX_OUTST is never granted, even if it is the only requester.
- It becomes eligible again the cycle after its `rvalid_o` pulse.

## Structure
- Package `apu_package` holds `FP_WIDTH`, `WAPUTAG`, `NDSFLAGS_SQRT` and `NUSFLAGS_SQRT`. Add `SQRT_NREQ` and `SQRT_MAX_OUTST` there.
- Sub-module `sqrt_rr_arb`: combinational round-robin mask-and-priority logic (inputs `req`, `elig`, `rr_ptr`; outputs one-hot grant and winner index). Pointer register lives in the parent.
- All remaining logic lives in `fp_sqrt_sched`. The bench instantiates `fp_sqrt_wrapper` with `C_SQRT_PIPE_REGS=SQRT_LAT`.

## Test plan
- Single request: requester 2 sends `opa_i=0x40800000` (4.0) with tag 0x5 at cycle 0. Expect `gnt_o=0b0100` at cycle 0, then at cycle 4 `rvalid_o=0b0100`, `res_o=0x40000000` and `tag_o=0x5`.
- Round-robin: all four requesters request continuously from reset. Expect grant order 0,1,2,3,0,… and results returned in the same order, one per cycle.
- Outstanding limit: requester 1 alone requests continuously with default parameters. Expect grants at cycles 0 and 1, no grant in cycles 2–4, a new grant at cycle 5 (after `rvalid_o[1]` at cycle 4), and steady state 2 grants per 5 cycles.
- Simultaneous increment/decrement: requester 0's result returns in the same cycle it is granted again. Expect `outst[0]` unchanged.
- Valid mismatch: force `unit_valid_i=1` with an empty pipe. Expect `err_o=1` the next cycle, no `rvalid_o`, and `err_o` held until reset.
- Mid-flight reset: assert `rst_ni=0` for 1 cycle with 3 operations in flight, resetting the unit too. Expect all outputs 0, no `rvalid_o` afterwards, `err_o=0`, and the next arbitration starting at requester 0.

Source files
------------

// File: rtl/apu_package.sv
// apu_package: shared APU widths plus the sqrt scheduler defaults.
//
// Contents:
//   FP_WIDTH, WAPUTAG          operand width and tag width
//   NDSFLAGS_SQRT              rounding-mode field width fed to the sqrt unit
//   NUSFLAGS_SQRT              status field width returned by the sqrt unit
//   SQRT_NREQ, SQRT_MAX_OUTST  default requester count and per-requester limit
//   OUTST_W                    width of the per-requester outstanding counters
//   sqrt_res_t                 payload captured by the scheduler's result register
package apu_package;

  localparam int FP_WIDTH       = 32;
  localparam int WAPUTAG        = 5;
  localparam int NDSFLAGS_SQRT  = 3;
  localparam int NUSFLAGS_SQRT  = 5;

  localparam int SQRT_NREQ      = 4;
  localparam int SQRT_MAX_OUTST = 2;

  // Three bits cover the largest allowed MAX_OUTST of 7.
  localparam int OUTST_W        = 3;

  typedef struct packed {
    logic [FP_WIDTH-1:0]      res;
    logic [WAPUTAG-1:0]       tag;
    logic [NUSFLAGS_SQRT-1:0] status;
  } sqrt_res_t;

endpackage

// File: rtl/sqrt_rr_arb.sv
// sqrt_rr_arb: combinational round-robin arbiter for the shared sqrt unit.
//
// Ports:
//   req      in  NREQ  raw requests
//   elig     in  NREQ  requester has room for another in-flight operation
//   rr_ptr   in  IDW   index with highest priority this cycle
//   gnt      out NREQ  one-hot grant (all zero when nobody is eligible)
//   win_idx  out IDW   index of the granted requester (0 when none)
//   win_vld  out 1     a grant was issued
//
// The pointer register itself lives in the parent so that it only advances
// on a completed transfer.
module sqrt_rr_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] elig,
  input  logic [IDW-1:0]  rr_ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  win_idx,
  output logic            win_vld
);

  logic [NREQ-1:0] cand;

  assign cand = req & elig;

  // Walk the candidates starting at rr_ptr and wrapping at NREQ; the first
  // hit wins. The wrap is done arithmetically so non-power-of-two NREQ works.
  always_comb begin
    int             idx;
    logic [IDW-1:0] sel;
    gnt     = '0;
    win_idx = '0;
    win_vld = 1'b0;
    idx     = 0;
    sel     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      sel = IDW'(idx);
      if (!win_vld && cand[sel]) begin
        win_vld  = 1'b1;
        win_idx  = sel;
        gnt[sel] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_sqrt_sched.sv
// fp_sqrt_sched: shares one pipelined sqrt unit among NREQ requesters.
//
// Ports:
//   clk_i, rst_ni             clock, synchronous active-low reset
//   req_i / gnt_o             per-requester request and one-hot grant
//   opa_i, tag_i, rnd_i       per-requester operand, tag and rounding mode
//   rvalid_o                  one-hot result-valid pulse to the originator
//   res_o, tag_o, status_o    shared registered result bus
//   unit_en_o .. unit_rnd_o   registered issue port to the sqrt unit
//   unit_valid_i .. unit_status_i  result port from the sqrt unit
//   busy_o                    work in flight or awaiting delivery
//   err_o                     sticky flag: unit valid disagreed with the ID pipe
//
// A grant in cycle t issues to the unit in t+1, the unit answers in
// t+1+SQRT_LAT and the result is delivered in t+2+SQRT_LAT. Requester IDs
// travel alongside in a shift register whose last stage lines up with the
// unit's valid, so results are routed back in issue order.
module fp_sqrt_sched
  import apu_package::*;
#(
  parameter int NREQ      = SQRT_NREQ,
  parameter int SQRT_LAT  = 2,
  parameter int MAX_OUTST = SQRT_MAX_OUTST
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NREQ-1:0]                     req_i,
  output logic [NREQ-1:0]                     gnt_o,
  input  logic [NREQ-1:0][FP_WIDTH-1:0]       opa_i,
  input  logic [NREQ-1:0][WAPUTAG-1:0]        tag_i,
  input  logic [NREQ-1:0][NDSFLAGS_SQRT-1:0]  rnd_i,
  output logic [NREQ-1:0]                     rvalid_o,
  output logic [FP_WIDTH-1:0]                 res_o,
  output logic [WAPUTAG-1:0]                  tag_o,
  output logic [NUSFLAGS_SQRT-1:0]            status_o,
  output logic                                unit_en_o,
  output logic [FP_WIDTH-1:0]                 unit_opa_o,
  output logic [WAPUTAG-1:0]                  unit_tag_o,
  output logic [NDSFLAGS_SQRT-1:0]            unit_rnd_o,
  input  logic                                unit_valid_i,
  input  logic [FP_WIDTH-1:0]                 unit_res_i,
  input  logic [WAPUTAG-1:0]                  unit_tag_i,
  input  logic [NUSFLAGS_SQRT-1:0]            unit_status_i,
  output logic                                busy_o,
  output logic                                err_o
);

  localparam int IDW = $clog2(NREQ);

  logic [IDW-1:0]     rr_ptr_q;
  logic [OUTST_W-1:0] outst [NREQ];
  logic [NREQ-1:0]    elig;
  logic [NREQ-1:0]    arb_gnt;
  logic [IDW-1:0]     win_idx;
  logic               win_vld;
  logic               transfer;

  logic [SQRT_LAT:0]  pipe_v;
  logic [IDW-1:0]     pipe_id [SQRT_LAT+1];
  logic               deliver;
  logic               mismatch;
  sqrt_res_t          res_q;

  // A requester already holding MAX_OUTST operations sits out arbitration
  // until one of its results has been delivered.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = (outst[i] < OUTST_W'(MAX_OUTST));
    end
  end

  sqrt_rr_arb #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req     (req_i),
    .elig    (elig),
    .rr_ptr  (rr_ptr_q),
    .gnt     (arb_gnt),
    .win_idx (win_idx),
    .win_vld (win_vld)
  );

  // Grants are suppressed while reset is asserted so nothing is accepted
  // that the cleared state would then lose track of.
  assign gnt_o    = rst_ni ? arb_gnt : '0;
  assign transfer = win_vld && rst_ni && |(req_i & gnt_o);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
    end else if (transfer) begin
      rr_ptr_q <= (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  // The issue register carries zeros on idle cycles so the unit never sees
  // stale operands.
  always_ff @(posedge clk_i) begin
    if (rst_ni && transfer) begin
      unit_en_o  <= 1'b1;
      unit_opa_o <= opa_i[win_idx];
      unit_tag_o <= tag_i[win_idx];
      unit_rnd_o <= rnd_i[win_idx];
    end else begin
      unit_en_o  <= 1'b0;
      unit_opa_o <= '0;
      unit_tag_o <= '0;
      unit_rnd_o <= '0;
    end
  end

  // Stage 0 loads with the issue register; stage SQRT_LAT therefore holds
  // the ID of the operation the unit is presenting this cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pipe_v <= '0;
      for (int k = 0; k <= SQRT_LAT; k++) begin
        pipe_id[k] <= '0;
      end
    end else begin
      pipe_v     <= {pipe_v[SQRT_LAT-1:0], transfer};
      pipe_id[0] <= win_idx;
      for (int k = 1; k <= SQRT_LAT; k++) begin
        pipe_id[k] <= pipe_id[k-1];
      end
    end
  end

  assign deliver  = pipe_v[SQRT_LAT] & unit_valid_i;
  assign mismatch = pipe_v[SQRT_LAT] ^ unit_valid_i;

  // A result is only accepted when both sides agree; a lone unit valid or a
  // missing one is dropped and recorded in err_o instead.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rvalid_o <= '0;
      res_q    <= '0;
    end else begin
      rvalid_o <= deliver ? (NREQ'(1) << pipe_id[SQRT_LAT]) : '0;
      if (deliver) begin
        res_q.res    <= unit_res_i;
        res_q.tag    <= unit_tag_i;
        res_q.status <= unit_status_i;
      end
    end
  end

  assign res_o    = res_q.res;
  assign tag_o    = res_q.tag;
  assign status_o = res_q.status;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_o <= 1'b0;
    end else if (mismatch) begin
      err_o <= 1'b1;
    end
  end

  // Counters track issue-to-delivery; a grant and a delivery for the same
  // requester in one cycle cancel out.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREQ; i++) begin
        outst[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if ((req_i[i] && gnt_o[i]) && !rvalid_o[i]) begin
          outst[i] <= outst[i] + 1'b1;
        end else if (!(req_i[i] && gnt_o[i]) && rvalid_o[i]) begin
          outst[i] <= outst[i] - 1'b1;
        end
      end
    end
  end

  always_comb begin
    busy_o = (|pipe_v) | unit_en_o;
    for (int i = 0; i < NREQ; i++) begin
      if (outst[i] != '0) begin
        busy_o = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fp_sqrt_sched.sv
// tb_fp_sqrt_sched: self-checking bench for fp_sqrt_sched.
// A behavioural sqrt unit with SQRT_LAT register stages sits behind the
// scheduler. A transaction-level model (grant rule, fixed issue-to-result
// latency, result queue, per-requester counts) predicts every output.
module tb_fp_sqrt_sched;
  import apu_package::*;

  localparam int NREQ      = 4;
  localparam int SQRT_LAT  = 2;
  localparam int MAX_OUTST = 2;
  localparam int RES_LAT   = SQRT_LAT + 2;

  logic clk = 1'b0;
  logic rst_ni;
  always #5 clk = ~clk;

  logic [NREQ-1:0]                    req;
  logic [NREQ-1:0]                    gnt_o;
  logic [NREQ-1:0][FP_WIDTH-1:0]      opa;
  logic [NREQ-1:0][WAPUTAG-1:0]       tags;
  logic [NREQ-1:0][NDSFLAGS_SQRT-1:0] rnds;
  logic [NREQ-1:0]                    rvalid_o;
  logic [FP_WIDTH-1:0]                res_o;
  logic [WAPUTAG-1:0]                 tag_o;
  logic [NUSFLAGS_SQRT-1:0]           status_o;
  logic                               unit_en;
  logic [FP_WIDTH-1:0]                unit_opa;
  logic [WAPUTAG-1:0]                 unit_tag;
  logic [NDSFLAGS_SQRT-1:0]           unit_rnd;
  logic                               unit_valid;
  logic [FP_WIDTH-1:0]                unit_res;
  logic [WAPUTAG-1:0]                 unit_tag_r;
  logic [NUSFLAGS_SQRT-1:0]           unit_status;
  logic                               busy_o;
  logic                               err_o;
  logic                               inj_valid;

  fp_sqrt_sched #(
    .NREQ      (NREQ),
    .SQRT_LAT  (SQRT_LAT),
    .MAX_OUTST (MAX_OUTST)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .req_i         (req),
    .gnt_o         (gnt_o),
    .opa_i         (opa),
    .tag_i         (tags),
    .rnd_i         (rnds),
    .rvalid_o      (rvalid_o),
    .res_o         (res_o),
    .tag_o         (tag_o),
    .status_o      (status_o),
    .unit_en_o     (unit_en),
    .unit_opa_o    (unit_opa),
    .unit_tag_o    (unit_tag),
    .unit_rnd_o    (unit_rnd),
    .unit_valid_i  (unit_valid),
    .unit_res_i    (unit_res),
    .unit_tag_i    (unit_tag_r),
    .unit_status_i (unit_status),
    .busy_o        (busy_o),
    .err_o         (err_o)
  );

  // Square root of a positive normal single, via double precision,
  // truncating the mantissa back to 23 bits.
  function automatic logic [31:0] sqrt_fn(input logic [31:0] a);
    logic [63:0] db;
    logic [63:0] rb;
    logic [10:0] e;
    real         r;
    if (a[30:23] == 8'd0) return 32'd0;
    e  = {3'b000, a[30:23]} + 11'd896;
    db = {1'b0, e, a[22:0], 29'd0};
    r  = $sqrt($bitstoreal(db));
    rb = $realtobits(r);
    e  = rb[62:52] - 11'd896;
    return {1'b0, e[7:0], rb[51:29]};
  endfunction

  function automatic logic [NUSFLAGS_SQRT-1:0] stat_fn(input logic [31:0] a,
                                                       input logic [NDSFLAGS_SQRT-1:0] rm);
    return {2'b00, rm} ^ a[4:0];
  endfunction

  // Behavioural sqrt unit; reset together with the scheduler.
  logic [SQRT_LAT-1:0]      u_v;
  logic [31:0]              u_res [SQRT_LAT];
  logic [WAPUTAG-1:0]       u_tag [SQRT_LAT];
  logic [NUSFLAGS_SQRT-1:0] u_st  [SQRT_LAT];

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      u_v <= '0;
      for (int k = 0; k < SQRT_LAT; k++) begin
        u_res[k] <= '0;
        u_tag[k] <= '0;
        u_st[k]  <= '0;
      end
    end else begin
      u_v[0]   <= unit_en;
      u_res[0] <= sqrt_fn(unit_opa);
      u_tag[0] <= unit_tag;
      u_st[0]  <= stat_fn(unit_opa, unit_rnd);
      for (int k = 1; k < SQRT_LAT; k++) begin
        u_v[k]   <= u_v[k-1];
        u_res[k] <= u_res[k-1];
        u_tag[k] <= u_tag[k-1];
        u_st[k]  <= u_st[k-1];
      end
    end
  end

  assign unit_valid  = u_v[SQRT_LAT-1] | inj_valid;
  assign unit_res    = u_res[SQRT_LAT-1];
  assign unit_tag_r  = u_tag[SQRT_LAT-1];
  assign unit_status = u_st[SQRT_LAT-1];

  // Reference model state.
  typedef struct {
    int                       due;
    int                       id;
    logic [31:0]              res;
    logic [WAPUTAG-1:0]       tag;
    logic [NUSFLAGS_SQRT-1:0] st;
  } exp_t;

  exp_t            exp_q[$];
  int              m_ptr;
  int              m_outst [NREQ];
  bit              m_err;
  int              cyc;
  int              total;
  int              bad;
  logic [NREQ-1:0] last_gnt;
  logic [NREQ-1:0] last_rvalid;

  typedef struct {
    int                 rq;
    logic [31:0]        opa;
    logic [WAPUTAG-1:0] tag;
    logic [2:0]         rnd;
    logic [NREQ-1:0]    exp_gnt;
    logic [31:0]        exp_res;
    logic [WAPUTAG-1:0] exp_tag;
  } vec_t;

  vec_t vecs [5];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at cyc %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask

  task automatic modelReset();
    exp_q.delete();
    m_ptr = 0;
    m_err = 1'b0;
    cyc   = 0;
    for (int i = 0; i < NREQ; i++) m_outst[i] = 0;
  endtask

  // Called at a negedge with this cycle's inputs already driven. Compares
  // the current cycle, advances the model over the next edge, and returns
  // at the following negedge.
  task automatic applyStimulus();
    int              w;
    int              idx;
    logic [NREQ-1:0] eg;
    logic [NREQ-1:0] er;
    bit              busy_e;
    exp_t            e;
    #1;
    w = -1;
    for (int k = 0; k < NREQ; k++) begin
      idx = (m_ptr + k) % NREQ;
      if (w < 0 && req[idx] && m_outst[idx] < MAX_OUTST) w = idx;
    end
    eg = (w >= 0) ? (NREQ'(1) << w) : '0;
    er = '0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) er = NREQ'(1) << exp_q[0].id;
    busy_e = 1'b0;
    for (int k = 0; k < NREQ; k++) if (m_outst[k] != 0) busy_e = 1'b1;

    checkOutput("gnt", 64'(gnt_o), 64'(eg));
    checkOutput("rvalid", 64'(rvalid_o), 64'(er));
    checkOutput("busy", 64'(busy_o), 64'(busy_e));
    checkOutput("err", 64'(err_o), 64'(m_err));
    if (er != '0) begin
      checkOutput("res", 64'(res_o), 64'(exp_q[0].res));
      checkOutput("tag", 64'(tag_o), 64'(exp_q[0].tag));
      checkOutput("status", 64'(status_o), 64'(exp_q[0].st));
    end
    last_gnt    = gnt_o;
    last_rvalid = rvalid_o;

    if (w >= 0) begin
      e.due = cyc + RES_LAT;
      e.id  = w;
      e.res = sqrt_fn(opa[w]);
      e.tag = tags[w];
      e.st  = stat_fn(opa[w], rnds[w]);
      exp_q.push_back(e);
      m_outst[w]++;
      m_ptr = (w + 1) % NREQ;
    end
    if (er != '0) begin
      m_outst[exp_q[0].id]--;
      void'(exp_q.pop_front());
    end
    cyc++;
    @(negedge clk);
  endtask

  // Enter at a negedge; holds reset across exactly one rising edge.
  task automatic resetDut();
    rst_ni = 1'b0;
    req    = '1;
    #1;
    checkOutput("gnt_in_reset", 64'(gnt_o), 64'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    req    = '0;
    modelReset();
    checkOutput("rst_rvalid", 64'(rvalid_o), 64'd0);
    checkOutput("rst_unit_en", 64'(unit_en), 64'd0);
    checkOutput("rst_res", 64'(res_o), 64'd0);
    checkOutput("rst_busy", 64'(busy_o), 64'd0);
    checkOutput("rst_err", 64'(err_o), 64'd0);
  endtask

  task automatic idle(input int n);
    req = '0;
    for (int k = 0; k < n; k++) applyStimulus();
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit exp_hit;
    total     = 0;
    bad       = 0;
    inj_valid = 1'b0;
    rst_ni    = 1'b0;
    req       = '0;
    modelReset();
    for (int i = 0; i < NREQ; i++) begin
      opa[i]  = '0;
      tags[i] = '0;
      rnds[i] = '0;
    end

    vecs[0] = '{2, 32'h40800000, 5'h05, 3'd1, 4'b0100, 32'h40000000, 5'h05};
    vecs[1] = '{0, 32'h41800000, 5'h11, 3'd2, 4'b0001, 32'h40800000, 5'h11};
    vecs[2] = '{3, 32'h3F800000, 5'h1F, 3'd0, 4'b1000, 32'h3F800000, 5'h1F};
    vecs[3] = '{1, 32'h41100000, 5'h0A, 3'd4, 4'b0010, 32'h40400000, 5'h0A};
    vecs[4] = '{2, 32'h3E800000, 5'h00, 3'd7, 4'b0100, 32'h3F000000, 5'h00};

    @(negedge clk);
    resetDut();

    $display("[TB] round-robin with all requesters active");
    for (int i = 0; i < NREQ; i++) begin
      opa[i]  = {1'b0, 8'(127 + 2 * i), 23'd0};
      tags[i] = 5'(i + 1);
      rnds[i] = 3'(i);
    end
    req = '1;
    for (int k = 0; k < 12; k++) begin
      applyStimulus();
      checkOutput("rr_order", 64'(last_gnt), 64'(NREQ'(1) << (k % NREQ)));
      if (k >= RES_LAT)
        checkOutput("rr_result_order", 64'(last_rvalid), 64'(NREQ'(1) << ((k - RES_LAT) % NREQ)));
      if (k == RES_LAT)
        checkOutput("outst0_inc_dec", 64'(dut.outst[0]), 64'd1);
    end
    idle(6);

    $display("[TB] single-request vectors");
    for (int v = 0; v < 5; v++) begin
      opa[vecs[v].rq]  = vecs[v].opa;
      tags[vecs[v].rq] = vecs[v].tag;
      rnds[vecs[v].rq] = vecs[v].rnd;
      req              = NREQ'(1) << vecs[v].rq;
      applyStimulus();
      checkOutput("vec_gnt", 64'(last_gnt), 64'(vecs[v].exp_gnt));
      req = '0;
      for (int k = 1; k <= RES_LAT; k++) applyStimulus();
      checkOutput("vec_rvalid", 64'(last_rvalid), 64'(vecs[v].exp_gnt));
      checkOutput("vec_res", 64'(res_o), 64'(vecs[v].exp_res));
      checkOutput("vec_tag", 64'(tag_o), 64'(vecs[v].exp_tag));
      idle(1);
    end

    $display("[TB] outstanding limit on requester 1");
    req = 4'b0010;
    for (int k = 0; k < 12; k++) begin
      applyStimulus();
      exp_hit = (k % 5 == 0) || (k % 5 == 1);
      checkOutput("limit_gnt", 64'(last_gnt), exp_hit ? 64'd2 : 64'd0);
    end
    idle(6);

    $display("[TB] randomized traffic");
    for (int k = 0; k < 300; k++) begin
      req = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        opa[i]  = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
        tags[i] = WAPUTAG'($urandom);
        rnds[i] = NDSFLAGS_SQRT'($urandom);
      end
      applyStimulus();
    end
    idle(8);

    $display("[TB] unit valid with empty pipe");
    inj_valid = 1'b1;
    applyStimulus();
    inj_valid = 1'b0;
    m_err     = 1'b1;
    checkOutput("err_set", 64'(err_o), 64'd1);
    checkOutput("err_no_rvalid", 64'(rvalid_o), 64'd0);
    idle(4);

    $display("[TB] reset with work in flight");
    req = '1;
    for (int k = 0; k < 3; k++) applyStimulus();
    resetDut();
    idle(8);
    req = '1;
    applyStimulus();
    checkOutput("post_reset_first", 64'(last_gnt), 64'd1);
    idle(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
